// File: rtl/control_pipe_pkg.sv
// Shared encodings and the EX-stage control bundle for the RV32I control pipeline.
package riscv_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned RES_W = 2;
    localparam int unsigned FWD_W = 2;
    localparam int unsigned ALU_W = 3;

    localparam logic [RES_W-1:0] RES_ALU = 2'b00;
    localparam logic [RES_W-1:0] RES_MEM = 2'b01;
    localparam logic [RES_W-1:0] RES_PC4 = 2'b10;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic              regWrite;
        logic [RES_W-1:0]  resultSrc;
        logic              memWrite;
        logic              jump;
        logic              branch;
        logic [ALU_W-1:0]  aluControl;
        logic              aluSrc;
    } ctrl_e_t;

    // MEM result beats WB result; x0 is never a forwarding source
    function automatic logic [FWD_W-1:0] fwd_sel(
        input logic [REG_W-1:0] rs_e,
        input logic             reg_write_m,
        input logic [REG_W-1:0] rd_m,
        input logic             reg_write_w,
        input logic [REG_W-1:0] rd_w
    );
        if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) return FWD_MEM;
        if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/control_pipe_if.sv
// Decode-side control inputs and hazard/stage-control outputs of control_pipe.
interface control_pipe_if;
    import riscv_pkg::*;

    logic              regWriteD;
    logic [RES_W-1:0]  resultSrcD;
    logic              MemWriteD;
    logic              JumpD;
    logic              BranchD;
    logic [ALU_W-1:0]  ALUControlD;
    logic              ALUSrcD;
    logic [REG_W-1:0]  Rs1D;
    logic [REG_W-1:0]  Rs2D;
    logic [REG_W-1:0]  RdD;
    logic              ZeroE;

    logic              StallF;
    logic              StallD;
    logic              FlushD;
    logic              PCSrcE;
    logic [FWD_W-1:0]  ForwardAE;
    logic [FWD_W-1:0]  ForwardBE;
    logic              RegWriteE;
    logic              MemWriteE;
    logic              ALUSrcE;
    logic [RES_W-1:0]  ResultSrcE;
    logic [ALU_W-1:0]  ALUControlE;
    logic [REG_W-1:0]  RdE;
    logic              RegWriteM;
    logic              MemWriteM;
    logic [RES_W-1:0]  ResultSrcM;
    logic [REG_W-1:0]  RdM;
    logic              RegWriteW;
    logic [RES_W-1:0]  ResultSrcW;
    logic [REG_W-1:0]  RdW;

    modport slave (
        input  regWriteD, resultSrcD, MemWriteD, JumpD, BranchD, ALUControlD, ALUSrcD,
               Rs1D, Rs2D, RdD, ZeroE,
        output StallF, StallD, FlushD, PCSrcE, ForwardAE, ForwardBE,
               RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, ALUControlE, RdE,
               RegWriteM, MemWriteM, ResultSrcM, RdM,
               RegWriteW, ResultSrcW, RdW
    );

    modport master (
        output regWriteD, resultSrcD, MemWriteD, JumpD, BranchD, ALUControlD, ALUSrcD,
               Rs1D, Rs2D, RdD, ZeroE,
        input  StallF, StallD, FlushD, PCSrcE, ForwardAE, ForwardBE,
               RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, ALUControlE, RdE,
               RegWriteM, MemWriteM, ResultSrcM, RdM,
               RegWriteW, ResultSrcW, RdW
    );
endinterface

// File: rtl/control_pipe_hazard_unit.sv
// Combinational hazard detection: load-use stall, branch/jump flush, EX operand forwarding.
module hazard_unit
    import riscv_pkg::*;
(
    input  logic [REG_W-1:0] i_rs1_d,
    input  logic [REG_W-1:0] i_rs2_d,
    input  logic [REG_W-1:0] i_rs1_e,
    input  logic [REG_W-1:0] i_rs2_e,
    input  logic [REG_W-1:0] i_rd_e,
    input  logic [RES_W-1:0] i_result_src_e,
    input  logic             i_branch_e,
    input  logic             i_jump_e,
    input  logic             i_zero_e,
    input  logic             i_reg_write_m,
    input  logic [REG_W-1:0] i_rd_m,
    input  logic             i_reg_write_w,
    input  logic [REG_W-1:0] i_rd_w,
    output logic             o_lw_stall_c,
    output logic             o_pc_src_c,
    output logic             o_flush_e_c,
    output logic [FWD_W-1:0] o_forward_a_c,
    output logic [FWD_W-1:0] o_forward_b_c
);
    logic w_use_hit;

    assign o_pc_src_c = (i_branch_e & i_zero_e) | i_jump_e;

    // A taken branch squashes the dependent instruction, so it never needs to stall
    assign w_use_hit    = (i_rd_e != '0) && ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));
    assign o_lw_stall_c = (i_result_src_e == RES_MEM) && w_use_hit && !o_pc_src_c;
    assign o_flush_e_c  = o_lw_stall_c | o_pc_src_c;

    assign o_forward_a_c = fwd_sel(i_rs1_e, i_reg_write_m, i_rd_m, i_reg_write_w, i_rd_w);
    assign o_forward_b_c = fwd_sel(i_rs2_e, i_reg_write_m, i_rd_m, i_reg_write_w, i_rd_w);
endmodule

// File: rtl/control_pipe.sv
// ID/EX, EX/MEM, MEM/WB control registers of the 5-stage RV32I core with hazard
// detection and saturating stall/flush performance counters.
module control_pipe
    import riscv_pkg::*;
#(
    parameter int unsigned word_width = 32,
    parameter int unsigned cnt_width  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    control_pipe_if.slave        bus,
    output logic [cnt_width-1:0] stall_cnt,
    output logic [cnt_width-1:0] flush_cnt
);
    if ((word_width == 0) || (cnt_width == 0)) begin : g_bad_width
        $error("control_pipe: word_width and cnt_width must be nonzero");
    end

    localparam logic [cnt_width-1:0] CNT_MAX = {cnt_width{1'b1}};

    ctrl_e_t          w_ctrl_d;
    ctrl_e_t          r_ctrl_e;
    logic [REG_W-1:0] r_rs1_e, r_rs2_e, r_rd_e;
    logic             r_reg_write_m, r_mem_write_m;
    logic [RES_W-1:0] r_result_src_m;
    logic [REG_W-1:0] r_rd_m;
    logic             r_reg_write_w;
    logic [RES_W-1:0] r_result_src_w;
    logic [REG_W-1:0] r_rd_w;
    logic [cnt_width-1:0] r_stall_cnt, r_flush_cnt;

    logic             w_lw_stall, w_pc_src, w_flush_e;
    logic [FWD_W-1:0] w_forward_a, w_forward_b;

    assign w_ctrl_d = '{regWrite:   bus.regWriteD,
                        resultSrc:  bus.resultSrcD,
                        memWrite:   bus.MemWriteD,
                        jump:       bus.JumpD,
                        branch:     bus.BranchD,
                        aluControl: bus.ALUControlD,
                        aluSrc:     bus.ALUSrcD};

    hazard_unit u_hazard (
        .i_rs1_d        (bus.Rs1D),
        .i_rs2_d        (bus.Rs2D),
        .i_rs1_e        (r_rs1_e),
        .i_rs2_e        (r_rs2_e),
        .i_rd_e         (r_rd_e),
        .i_result_src_e (r_ctrl_e.resultSrc),
        .i_branch_e     (r_ctrl_e.branch),
        .i_jump_e       (r_ctrl_e.jump),
        .i_zero_e       (bus.ZeroE),
        .i_reg_write_m  (r_reg_write_m),
        .i_rd_m         (r_rd_m),
        .i_reg_write_w  (r_reg_write_w),
        .i_rd_w         (r_rd_w),
        .o_lw_stall_c   (w_lw_stall),
        .o_pc_src_c     (w_pc_src),
        .o_flush_e_c    (w_flush_e),
        .o_forward_a_c  (w_forward_a),
        .o_forward_b_c  (w_forward_b)
    );

    // EX loads a bubble on flush; MEM and WB advance unconditionally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl_e       <= '0;
            r_rs1_e        <= '0;
            r_rs2_e        <= '0;
            r_rd_e         <= '0;
            r_reg_write_m  <= 1'b0;
            r_mem_write_m  <= 1'b0;
            r_result_src_m <= '0;
            r_rd_m         <= '0;
            r_reg_write_w  <= 1'b0;
            r_result_src_w <= '0;
            r_rd_w         <= '0;
        end else begin
            if (w_flush_e) begin
                r_ctrl_e <= '0;
                r_rs1_e  <= '0;
                r_rs2_e  <= '0;
                r_rd_e   <= '0;
            end else begin
                r_ctrl_e <= w_ctrl_d;
                r_rs1_e  <= bus.Rs1D;
                r_rs2_e  <= bus.Rs2D;
                r_rd_e   <= bus.RdD;
            end
            r_reg_write_m  <= r_ctrl_e.regWrite;
            r_mem_write_m  <= r_ctrl_e.memWrite;
            r_result_src_m <= r_ctrl_e.resultSrc;
            r_rd_m         <= r_rd_e;
            r_reg_write_w  <= r_reg_write_m;
            r_result_src_w <= r_result_src_m;
            r_rd_w         <= r_rd_m;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_lw_stall && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + cnt_width'(1);
            if (w_pc_src && (r_flush_cnt != CNT_MAX))   r_flush_cnt <= r_flush_cnt + cnt_width'(1);
        end
    end

    assign bus.StallF      = w_lw_stall;
    assign bus.StallD      = w_lw_stall;
    assign bus.FlushD      = w_pc_src;
    assign bus.PCSrcE      = w_pc_src;
    assign bus.ForwardAE   = w_forward_a;
    assign bus.ForwardBE   = w_forward_b;
    assign bus.RegWriteE   = r_ctrl_e.regWrite;
    assign bus.MemWriteE   = r_ctrl_e.memWrite;
    assign bus.ALUSrcE     = r_ctrl_e.aluSrc;
    assign bus.ResultSrcE  = r_ctrl_e.resultSrc;
    assign bus.ALUControlE = r_ctrl_e.aluControl;
    assign bus.RdE         = r_rd_e;
    assign bus.RegWriteM   = r_reg_write_m;
    assign bus.MemWriteM   = r_mem_write_m;
    assign bus.ResultSrcM  = r_result_src_m;
    assign bus.RdM         = r_rd_m;
    assign bus.RegWriteW   = r_reg_write_w;
    assign bus.ResultSrcW  = r_result_src_w;
    assign bus.RdW         = r_rd_w;
    assign stall_cnt       = r_stall_cnt;
    assign flush_cnt       = r_flush_cnt;
endmodule
